// File: rtl/chroni_text_fetch_pkg.sv
// chroni_text_fetch_pkg
// Shared definitions for the text-mode line fetch engine: FSM state
// encoding, row-buffer cell layout and attribute nibble positions.
package chroni_text_fetch_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TEXT_REQ,
    TEXT_WAIT,
    FONT_ADDR,
    FONT_SETTLE,
    FONT_REQ,
    FONT_WAIT,
    PUSH,
    NEXT
  } state_t;

  // Row-buffer cell: character code in the low byte, attribute in the high byte.
  localparam int CELL_CHAR_LSB = 0;
  localparam int CELL_ATTR_LSB = 8;

  // Attribute byte: foreground nibble low, background nibble high.
  localparam int ATTR_FG_LSB = 0;
  localparam int ATTR_BG_LSB = 4;

  function automatic logic [7:0] attr_colour(input logic [3:0] page,
                                             input logic [7:0] attr,
                                             input int         lsb);
    return {page, attr[lsb +: 4]};
  endfunction

endpackage

// File: rtl/chroni_text_fetch_spram.sv
// chroni_text_fetch_spram
// Single-port RAM used as the text row buffer. Write and read share one
// address; q is registered, so it shows mem[addr] one cycle after addr.
// Ports:
//   sys_clk  clock
//   we       write enable
//   addr     word address (addresses >= DEPTH are ignored / read as 0)
//   d        write data
//   q        registered read data
module chroni_text_fetch_spram #(
  parameter int DEPTH = 80,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic          in_range;

  assign idx      = addr[IW-1:0];
  assign in_range = (addr < AW'(DEPTH));

  always_ff @(posedge sys_clk) begin
    if (we && in_range) mem[idx] <= d;
    q <= in_range ? mem[idx] : '0;
  end

endmodule

// File: rtl/chroni_text_fetch.sv
// chroni_text_fetch
// Text-mode line fetch engine. On each line_start it reads one row of
// character cells into a local row buffer (only on font scanline 0), then
// fetches one font byte per column for the current scanline and pushes it,
// with its palette indices, to the line-buffer writer.
// Ports:
//   sys_clk, reset_n             clock, synchronous active-low reset
//   frame_start, line_start      frame restart / render-one-line pulses
//   buf_sel                      line-buffer half (sampled on line_start)
//   text_base, attr_en           frame text origin / cell format (on frame_start)
//   font_base                    font table base, aligned to 256*FONT_ROWS
//   fg_default, bg_default       colours when attr_en=0
//   pal_page                     palette page when attr_en=1
//   rd_addr, rd_req, rd_ack, rd_data   memory read port
//   wr_addr, wr_data, wr_on, wr_off, wr_bits, wr_en, wr_busy   line-buffer writer
//   dma_req                      high while a line is being rendered
//   overrun                      line_start arrived while busy
//
// state       | meaning
// IDLE        | waiting for line_start
// TEXT_REQ    | issue text/attr byte read at row_ptr + byte_idx
// TEXT_WAIT   | wait for rd_ack, store byte into row buffer
// FONT_ADDR   | present column to row buffer
// FONT_SETTLE | row buffer q becomes valid
// FONT_REQ    | issue font byte read from registered q
// FONT_WAIT   | wait for rd_ack, then for wr_busy to clear
// PUSH        | one-cycle write strobe to line buffer
// NEXT        | advance column, or close the line
module chroni_text_fetch
  import chroni_text_fetch_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int FONT_ROWS = 8,
  parameter int ADDR_W    = 16,
  parameter int LINE_W    = 640
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              buf_sel,
  input  logic [ADDR_W-1:0] text_base,
  input  logic [ADDR_W-1:0] font_base,
  input  logic              attr_en,
  input  logic [7:0]        fg_default,
  input  logic [7:0]        bg_default,
  input  logic [3:0]        pal_page,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic [10:0]       wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        wr_on,
  output logic [7:0]        wr_off,
  output logic [3:0]        wr_bits,
  output logic              wr_en,
  input  logic              wr_busy,
  output logic              dma_req,
  output logic              overrun
);

  localparam int SCAN_W = $clog2(FONT_ROWS);

  state_t             state, state_nxt;
  logic [SCAN_W-1:0]  scan;
  logic [ADDR_W-1:0]  row_ptr;
  logic               attr_q;
  logic               buf_q;
  logic               have_glyph;
  logic [8:0]         byte_idx;
  logic [7:0]         col;
  logic [7:0]         char_hold;

  logic               ack_ok;
  logic [8:0]         text_bytes;
  logic               text_last;
  logic               col_last;

  logic               ram_we;
  logic [7:0]         ram_addr;
  logic [15:0]        ram_d;
  logic [15:0]        ram_q;
  logic [7:0]         cell_char;
  logic [7:0]         cell_attr;

  // An ack only counts against an outstanding request; stray acks after a
  // frame_start abort fall through here.
  assign ack_ok     = rd_ack & rd_req;
  assign text_bytes = attr_q ? 9'(2 * COLS) : 9'(COLS);
  assign text_last  = (byte_idx == text_bytes - 9'd1);
  assign col_last   = (col == 8'(COLS - 1));
  assign wr_bits    = 4'd8;
  assign wr_en      = (state == PUSH);
  assign cell_char  = ram_q[CELL_CHAR_LSB +: 8];
  assign cell_attr  = ram_q[CELL_ATTR_LSB +: 8];

  // With attributes, the char byte is held until its attr byte arrives so the
  // cell is written as one 16-bit word.
  always_comb begin
    ram_addr = col;
    ram_we   = 1'b0;
    ram_d    = {8'h00, rd_data};
    if (state == TEXT_REQ || state == TEXT_WAIT) begin
      ram_addr = attr_q ? byte_idx[8:1] : byte_idx[7:0];
      ram_we   = (state == TEXT_WAIT) & ack_ok & ~frame_start & (~attr_q | byte_idx[0]);
      ram_d    = attr_q ? {rd_data, char_hold} : {8'h00, rd_data};
    end
  end

  chroni_text_fetch_spram #(
    .DEPTH (COLS),
    .AW    (8),
    .DW    (16)
  ) u_row_buf (
    .sys_clk (sys_clk),
    .we      (ram_we),
    .addr    (ram_addr),
    .d       (ram_d),
    .q       (ram_q)
  );

  always_ff @(posedge sys_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:        if (line_start) state_nxt = (scan == '0) ? TEXT_REQ : FONT_ADDR;
        TEXT_REQ:    state_nxt = TEXT_WAIT;
        TEXT_WAIT:   if (ack_ok) state_nxt = text_last ? FONT_ADDR : TEXT_REQ;
        FONT_ADDR:   state_nxt = FONT_SETTLE;
        FONT_SETTLE: state_nxt = FONT_REQ;
        FONT_REQ:    state_nxt = FONT_WAIT;
        FONT_WAIT:   if ((ack_ok || have_glyph) && !wr_busy) state_nxt = PUSH;
        PUSH:        state_nxt = NEXT;
        NEXT:        state_nxt = col_last ? IDLE : FONT_ADDR;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      scan       <= '0;
      row_ptr    <= '0;
      attr_q     <= 1'b0;
      buf_q      <= 1'b0;
      have_glyph <= 1'b0;
      byte_idx   <= '0;
      col        <= '0;
      char_hold  <= '0;
      rd_addr    <= '0;
      rd_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_on      <= '0;
      wr_off     <= '0;
      dma_req    <= 1'b0;
      overrun    <= 1'b0;
    end else if (frame_start) begin
      row_ptr    <= text_base;
      scan       <= '0;
      attr_q     <= attr_en;
      rd_req     <= 1'b0;
      dma_req    <= 1'b0;
      have_glyph <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= line_start & (state != IDLE);
      case (state)
        IDLE: begin
          if (line_start) begin
            dma_req  <= 1'b1;
            buf_q    <= buf_sel;
            byte_idx <= '0;
            col      <= '0;
          end
        end
        TEXT_REQ: begin
          rd_addr <= row_ptr + ADDR_W'(byte_idx);
          rd_req  <= 1'b1;
        end
        TEXT_WAIT: begin
          if (ack_ok) begin
            rd_req   <= 1'b0;
            byte_idx <= byte_idx + 9'd1;
            if (attr_q && !byte_idx[0]) char_hold <= rd_data;
          end
        end
        FONT_REQ: begin
          // font_base is aligned, so the add never carries into the base bits.
          rd_addr    <= font_base + ADDR_W'({cell_char, scan});
          rd_req     <= 1'b1;
          have_glyph <= 1'b0;
          wr_addr    <= (buf_q ? 11'(LINE_W) : 11'd0) + {col, 3'b000};
          wr_on      <= attr_q ? attr_colour(pal_page, cell_attr, ATTR_FG_LSB) : fg_default;
          wr_off     <= attr_q ? attr_colour(pal_page, cell_attr, ATTR_BG_LSB) : bg_default;
        end
        FONT_WAIT: begin
          if (ack_ok) begin
            rd_req  <= 1'b0;
            wr_data <= rd_data;
            if (wr_busy) have_glyph <= 1'b1;
          end
        end
        PUSH: begin
          have_glyph <= 1'b0;
          if (col_last) dma_req <= 1'b0;
        end
        NEXT: begin
          if (col_last) begin
            scan <= scan + 1'b1;
            if (scan == SCAN_W'(FONT_ROWS - 1))
              row_ptr <= row_ptr + (attr_q ? ADDR_W'(2 * COLS) : ADDR_W'(COLS));
          end else begin
            col <= col + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chroni_text_fetch.sv
// tb_chroni_text_fetch
// Directed bench for chroni_text_fetch with COLS=4, FONT_ROWS=8. A memory
// model answers reads; a monitor logs reads and line-buffer writes, which the
// directed steps compare against hand-derived expectations.
module tb_chroni_text_fetch;

  localparam int COLS = 4;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        frame_start, line_start, buf_sel, attr_en;
  logic [15:0] text_base, font_base;
  logic [7:0]  fg_default, bg_default;
  logic [3:0]  pal_page;
  logic [15:0] rd_addr;
  logic        rd_req;
  logic        rd_ack = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data, wr_on, wr_off;
  logic [3:0]  wr_bits;
  logic        wr_en;
  logic        wr_busy = 1'b0;
  logic        dma_req, overrun;

  chroni_text_fetch #(.COLS(COLS), .FONT_ROWS(8), .ADDR_W(16), .LINE_W(640)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .frame_start(frame_start),
    .line_start(line_start), .buf_sel(buf_sel), .text_base(text_base),
    .font_base(font_base), .attr_en(attr_en), .fg_default(fg_default),
    .bg_default(bg_default), .pal_page(pal_page), .rd_addr(rd_addr),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_on(wr_on), .wr_off(wr_off), .wr_bits(wr_bits),
    .wr_en(wr_en), .wr_busy(wr_busy), .dma_req(dma_req), .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0]  mem [0:65535];
  int          n_chk = 0;
  int          n_err = 0;

  // Stimulus-side knobs (written only by the main sequence).
  logic        lat_rand = 1'b0;
  int          lat_fixed = 0;
  logic        force_ack = 1'b0;
  logic        busy_mode = 1'b0;

  // Monitor-side logs (written only by the monitor).
  logic [15:0] rd_log [$];
  logic [10:0] wa_log [$];
  logic [7:0]  wd_log [$], won_log [$], woff_log [$];
  int          ovr_cnt = 0, stab_err = 0, bviol = 0;

  int          rd0, wr0;

  // Memory responder: ack after cur_lat cycles of rd_req, one-cycle ack.
  int          wait_cnt = 0, cur_lat = 0;
  always @(posedge sys_clk) begin
    #1;
    if (rd_ack) begin
      rd_ack = 1'b0;
    end else if (force_ack) begin
      rd_ack  = 1'b1;
      rd_data = 8'hEE;
    end else if (rd_req) begin
      if (wait_cnt >= cur_lat) begin
        rd_ack   = 1'b1;
        rd_data  = mem[rd_addr];
        wait_cnt = 0;
        cur_lat  = lat_rand ? int'($urandom_range(5, 0)) : lat_fixed;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      cur_lat  = lat_rand ? int'($urandom_range(5, 0)) : lat_fixed;
    end
  end

  // Monitor plus wr_busy generator (busy for 6 cycles after each push).
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  int          busy_cnt = 0;
  always @(negedge sys_clk) begin
    if (rd_req && rd_ack) rd_log.push_back(rd_addr);
    if (rd_req && prev_req && rd_addr != prev_addr) stab_err++;
    prev_req  = rd_req;
    prev_addr = rd_addr;
    if (overrun) ovr_cnt++;
    if (wr_en) begin
      if (wr_busy) bviol++;
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
      won_log.push_back(wr_on);
      woff_log.push_back(wr_off);
    end
    if (wr_en && busy_mode) busy_cnt = 6;
    else if (busy_cnt > 0) busy_cnt--;
    wr_busy = (busy_cnt > 0);
  end

  function automatic logic [7:0] glyph(input logic [7:0] c, input int s);
    logic [15:0] a;
    a = 16'h2000 + {5'd0, c, 3'b000} + 16'(s);
    return a[7:0] ^ 8'h3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_frame(input logic [15:0] base, input logic attr);
    @(posedge sys_clk); #1;
    text_base   = base;
    attr_en     = attr;
    frame_start = 1'b1;
    @(posedge sys_clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_line(input logic bs);
    @(posedge sys_clk); #1;
    line_start = 1'b1;
    buf_sel    = bs;
    @(posedge sys_clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dma_req && n < 3000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("line_done", dma_req, 0);
    tick(2);
  endtask

  task automatic run_line(input logic bs);
    rd0 = rd_log.size();
    wr0 = wa_log.size();
    pulse_line(bs);
    chk("dma_rise", dma_req, 1);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w_before;
    int o_before;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h3C;
    for (int i = 0; i < 4; i++) begin
      mem[16'h0400 + i] = 8'h41 + 8'(i);
      mem[16'h0404 + i] = 8'h61 + 8'(i);
      mem[16'h0500 + 2 * i] = 8'h30 + 8'(i);
      mem[16'h0501 + 2 * i] = 8'h5A;
      mem[16'h0600 + i] = 8'h70 + 8'(i);
    end
    reset_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; buf_sel = 1'b0;
    attr_en = 1'b0; text_base = 16'h0000; font_base = 16'h2000;
    fg_default = 8'h0F; bg_default = 8'h01; pal_page = 4'h3;
    tick(4);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_on", wr_on, 0);
    chk("rst_wr_off", wr_off, 0);
    chk("rst_wr_bits", wr_bits, 8);
    chk("rst_dma_req", dma_req, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    tick(2);

    // Plain cells, scanline 0: text then font reads, four pushes.
    do_frame(16'h0400, 1'b0);
    run_line(1'b0);
    chk("a_nreads", rd_log.size() - rd0, 8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_text%0d", i), rd_log[rd0 + i], 16'h0400 + 16'(i));
      chk($sformatf("a_font%0d", i), rd_log[rd0 + 4 + i], 16'h2208 + 16'(8 * i));
      chk($sformatf("a_waddr%0d", i), wa_log[wr0 + i], 11'(8 * i));
      chk($sformatf("a_wdata%0d", i), wd_log[wr0 + i], glyph(8'h41 + 8'(i), 0));
      chk($sformatf("a_won%0d", i), won_log[wr0 + i], 8'h0F);
      chk($sformatf("a_woff%0d", i), woff_log[wr0 + i], 8'h01);
    end
    chk("a_nwrites", wa_log.size() - wr0, 4);

    // Scanlines 1..7: font only, no text refetch.
    for (int s = 1; s < 8; s++) begin
      run_line(1'b0);
      chk($sformatf("scan%0d_nreads", s), rd_log.size() - rd0, 4);
      chk($sformatf("scan%0d_font0", s), rd_log[rd0], 16'h2208 + 16'(s));
      chk($sformatf("scan%0d_wdata3", s), wd_log[wr0 + 3], glyph(8'h44, s));
    end

    // Ninth line: next text row at 0x0404, upper buffer half.
    run_line(1'b1);
    chk("row1_nreads", rd_log.size() - rd0, 8);
    chk("row1_text0", rd_log[rd0], 16'h0404);
    chk("row1_font0", rd_log[rd0 + 4], 16'h2308);
    chk("row1_last_waddr", wa_log[wr0 + 3], 11'd664);
    chk("row1_last_wdata", wd_log[wr0 + 3], glyph(8'h64, 0));

    // Attribute cells: alternating char/attr reads, paged colours.
    do_frame(16'h0500, 1'b1);
    run_line(1'b0);
    chk("b_nreads", rd_log.size() - rd0, 12);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b_text%0d", i), rd_log[rd0 + i], 16'h0500 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_font%0d", i), rd_log[rd0 + 8 + i], 16'h2180 + 16'(8 * i));
      chk($sformatf("b_won%0d", i), won_log[wr0 + i], 8'h3A);
      chk($sformatf("b_woff%0d", i), woff_log[wr0 + i], 8'h35);
      chk($sformatf("b_wdata%0d", i), wd_log[wr0 + i], glyph(8'h30 + 8'(i), 0));
    end

    // Random ack latency with a busy line-buffer writer.
    do_frame(16'h0400, 1'b0);
    lat_rand  = 1'b1;
    busy_mode = 1'b1;
    run_line(1'b0);
    chk("c_nwrites", wa_log.size() - wr0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_waddr%0d", i), wa_log[wr0 + i], 11'(8 * i));
      chk($sformatf("c_wdata%0d", i), wd_log[wr0 + i], glyph(8'h41 + 8'(i), 0));
    end
    chk("c_rd_addr_stable", stab_err, 0);
    chk("c_push_while_busy", bviol, 0);
    lat_rand  = 1'b0;
    busy_mode = 1'b0;
    tick(8);

    // frame_start while a text read is outstanding.
    lat_fixed = 20;
    do_frame(16'h0400, 1'b0);
    pulse_line(1'b0);
    tick(3);
    chk("d_in_wait", rd_req, 1);
    do_frame(16'h0600, 1'b0);
    chk("d_rd_req_clr", rd_req, 0);
    chk("d_dma_clr", dma_req, 0);
    chk("d_wr_en_clr", wr_en, 0);
    lat_fixed = 0;
    tick(2);
    w_before = wa_log.size();
    @(posedge sys_clk); #2;
    force_ack = 1'b1;
    @(posedge sys_clk); #2;
    force_ack = 1'b0;
    tick(3);
    chk("d_stray_ack_writes", wa_log.size(), w_before);
    chk("d_stray_ack_req", rd_req, 0);
    run_line(1'b0);
    chk("d_nreads", rd_log.size() - rd0, 8);
    chk("d_text0", rd_log[rd0], 16'h0600);
    chk("d_wdata0", wd_log[wr0], glyph(8'h70, 0));

    // line_start while busy: one overrun pulse, line still completes.
    o_before = ovr_cnt;
    rd0 = rd_log.size();
    wr0 = wa_log.size();
    pulse_line(1'b0);
    tick(4);
    pulse_line(1'b0);
    wait_idle();
    chk("e_overrun", ovr_cnt - o_before, 1);
    chk("e_nreads", rd_log.size() - rd0, 4);
    chk("e_font0", rd_log[rd0], 16'h2381);
    chk("e_nwrites", wa_log.size() - wr0, 4);
    chk("e_last_waddr", wa_log[wr0 + 3], 11'd24);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
